// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port register file: two combinational read ports, two
//             clocked write ports (ALU, load), optional hardwired zero
//             register, optional write-to-read bypass and a per-register
//             pending-load scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ReadAddr1,
    input  logic [ADDR_W-1:0] ReadAddr2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic [ADDR_W-1:0] WriteAddr0,
    input  logic [DATA_W-1:0] WriteData0,
    input  logic              RegWrite0,
    input  logic [ADDR_W-1:0] WriteAddr1,
    input  logic [DATA_W-1:0] WriteData1,
    input  logic              RegWrite1,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueAddr,
    output logic              AnyBusy
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Flattened view of every entry's stored value and pending-load flag.
    logic [DATA_W-1:0] w_regs [DEPTH];
    logic [DEPTH-1:0]  w_busy;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            if (ZERO_REG && (i == 0)) begin : g_zero
                // Register 0 is a constant: never written, never pending.
                assign w_regs[i] = '0;
                assign w_busy[i] = 1'b0;
            end else begin : g_store
                localparam logic [ADDR_W-1:0] c_ADDR = ADDR_W'(i);

                logic [DATA_W-1:0] data_q;
                logic [DATA_W-1:0] data_d;
                logic              busy_q;
                logic              busy_d;
                logic              w_wr0;
                logic              w_wr1;
                logic              w_issue;

                assign w_wr0   = RegWrite0 && (WriteAddr0 == c_ADDR);
                assign w_wr1   = RegWrite1 && (WriteAddr1 == c_ADDR);
                assign w_issue = IssueEn   && (IssueAddr  == c_ADDR);

                // Next state: load port overrides ALU port; a new issue
                // overrides the clear of the load that is retiring.
                always_comb begin
                    data_d = data_q;
                    busy_d = busy_q;
                    if (w_wr0) begin
                        data_d = WriteData0;
                    end
                    if (w_wr1) begin
                        data_d = WriteData1;
                        busy_d = 1'b0;
                    end
                    if (w_issue) begin
                        busy_d = 1'b1;
                    end
                end

                // Entry storage, cleared immediately by Reset.
                always_ff @(posedge Clock or posedge Reset) begin
                    if (Reset) begin
                        data_q <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        data_q <= data_d;
                        busy_q <= busy_d;
                    end
                end

                assign w_regs[i] = data_q;
                assign w_busy[i] = busy_q;
            end
        end
    endgenerate

    // Read ports share one implementation, indexed 0/1 for ports 1/2.
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic [1:0]        w_rbusy;

    assign w_raddr[0] = ReadAddr1;
    assign w_raddr[1] = ReadAddr2;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rport
            logic [DATA_W-1:0] w_rd;

            // Lowest priority first so later assignments take precedence:
            // stored value < ALU bypass < load bypass < zero reg < reset.
            always_comb begin
                w_rd = w_regs[w_raddr[p]];
                if (BYPASS) begin
                    if (RegWrite0 && (WriteAddr0 == w_raddr[p])) begin
                        w_rd = WriteData0;
                    end
                    if (RegWrite1 && (WriteAddr1 == w_raddr[p])) begin
                        w_rd = WriteData1;
                    end
                end
                if (ZERO_REG && (w_raddr[p] == '0)) begin
                    w_rd = '0;
                end
                if (Reset) begin
                    w_rd = '0;
                end
            end

            assign w_rdata[p] = w_rd;
            // Busy reflects registered state only; no issue bypass.
            assign w_rbusy[p] = w_busy[w_raddr[p]] & ~Reset;
        end
    endgenerate

    assign ReadData1 = w_rdata[0];
    assign ReadData2 = w_rdata[1];
    assign Busy1     = w_rbusy[0];
    assign Busy2     = w_rbusy[1];
    assign AnyBusy   = (|w_busy) & ~Reset;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp. Instance A uses the default
//             configuration (32x32, zero reg, bypass); instance B is 8x16 with
//             no zero reg and no bypass, driven by the low bits of the same
//             stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1, ra2, wa0, wa1, ia;
    logic [31:0] wd0, wd1;
    logic        we0, we1, iss;

    logic [31:0] rdA1, rdA2;
    logic        bA1, bA2, anyA;
    logic [15:0] rdB1, rdB2;
    logic        bB1, bB2, anyB;

    int checks = 0;
    int errors = 0;

    // Reference state: plain arrays updated by the architectural rules.
    logic [31:0] mA  [32];
    logic        mAb [32];
    logic [15:0] mB  [8];
    logic        mBb [8];

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .Clock(clk), .Reset(rst),
        .ReadAddr1(ra1), .ReadAddr2(ra2),
        .ReadData1(rdA1), .ReadData2(rdA2),
        .Busy1(bA1), .Busy2(bA2),
        .WriteAddr0(wa0), .WriteData0(wd0), .RegWrite0(we0),
        .WriteAddr1(wa1), .WriteData1(wd1), .RegWrite1(we1),
        .IssueEn(iss), .IssueAddr(ia),
        .AnyBusy(anyA)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .Clock(clk), .Reset(rst),
        .ReadAddr1(ra1[2:0]), .ReadAddr2(ra2[2:0]),
        .ReadData1(rdB1), .ReadData2(rdB2),
        .Busy1(bB1), .Busy2(bB2),
        .WriteAddr0(wa0[2:0]), .WriteData0(wd0[15:0]), .RegWrite0(we0),
        .WriteAddr1(wa1[2:0]), .WriteData1(wd1[15:0]), .RegWrite1(we1),
        .IssueEn(iss), .IssueAddr(ia[2:0]),
        .AnyBusy(anyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (rst)                 return 32'h0;
        if (a == 5'd0)           return 32'h0;
        if (we1 && (wa1 == a))   return wd1;
        if (we0 && (wa0 == a))   return wd0;
        return mA[a];
    endfunction

    function automatic logic [15:0] exp_b(input logic [2:0] a);
        if (rst) return 16'h0;
        return mB[a];
    endfunction

    function automatic logic any_a();
        logic r = 1'b0;
        for (int k = 0; k < 32; k++) r = r | mAb[k];
        return r & ~rst;
    endfunction

    function automatic logic any_b();
        logic r = 1'b0;
        for (int k = 0; k < 8; k++) r = r | mBb[k];
        return r & ~rst;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 32; k++) begin mA[k] = '0; mAb[k] = 1'b0; end
        for (int k = 0; k < 8; k++)  begin mB[k] = '0; mBb[k] = 1'b0; end
    endtask

    // Architectural effect of one rising edge with Reset low.
    task automatic model_edge();
        if (we0 && wa0 != 5'd0) mA[wa0] = wd0;
        if (we1 && wa1 != 5'd0) mA[wa1] = wd1;
        if (we1)                mAb[wa1] = 1'b0;
        if (iss && ia != 5'd0)  mAb[ia] = 1'b1;
        if (we0) mB[wa0[2:0]] = wd0[15:0];
        if (we1) mB[wa1[2:0]] = wd1[15:0];
        if (we1) mBb[wa1[2:0]] = 1'b0;
        if (iss) mBb[ia[2:0]] = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        check("A_rd1",  rdA1, exp_a(ra1));
        check("A_rd2",  rdA2, exp_a(ra2));
        check("A_busy1", {31'b0, bA1}, {31'b0, mAb[ra1] & ~rst});
        check("A_busy2", {31'b0, bA2}, {31'b0, mAb[ra2] & ~rst});
        check("A_any",  {31'b0, anyA}, {31'b0, any_a()});
        check("B_rd1",  {16'b0, rdB1}, {16'b0, exp_b(ra1[2:0])});
        check("B_rd2",  {16'b0, rdB2}, {16'b0, exp_b(ra2[2:0])});
        check("B_busy1", {31'b0, bB1}, {31'b0, mBb[ra1[2:0]] & ~rst});
        check("B_busy2", {31'b0, bB2}, {31'b0, mBb[ra2[2:0]] & ~rst});
        check("B_any",  {31'b0, anyB}, {31'b0, any_b()});
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; iss = 1'b0;
        wa0 = '0; wa1 = '0; ia = '0; wd0 = '0; wd1 = '0;
    endtask

    // Advance one cycle: edge updates the model, return at the next negedge.
    task automatic cyc();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        ra1 = '0; ra2 = '0;
        model_clear();
        #2;
        // Reset state across all addresses.
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            #1 check_all();
        end
        @(negedge clk);
        rst = 1'b0;

        // Write r5 then reset between edges.
        wa0 = 5'd5; wd0 = 32'hDEADBEEF; we0 = 1'b1; ra1 = 5'd5; ra2 = 5'd6;
        #1 check_all();
        cyc(); idle();
        #1 check("r5_stored", rdA1, 32'hDEADBEEF);
        check_all();
        rst = 1'b1; model_clear();
        #1 check("r5_async_reset", rdA1, 32'h0);
        check_all();
        #1 rst = 1'b0;
        cyc();

        // Bypass vs. no-bypass on r3.
        wa0 = 5'd3; wd0 = 32'h12345678; we0 = 1'b1; ra1 = 5'd3; ra2 = 5'd3;
        #1 check("r3_bypass_A", rdA1, 32'h12345678);
        check("r3_nobypass_B", {16'b0, rdB1}, 32'h0);
        check_all();
        cyc(); idle();
        #1 check("r3_next_B", {16'b0, rdB1}, 32'h5678);
        check_all();

        // Same-address collision: load port wins.
        wa0 = 5'd7; wd0 = 32'hAAAA0000; we0 = 1'b1;
        wa1 = 5'd7; wd1 = 32'h0000BBBB; we1 = 1'b1; ra1 = 5'd7;
        #1 check("r7_bypass_p1wins", rdA1, 32'h0000BBBB);
        check_all();
        cyc(); idle();
        #1 check("r7_p1wins", rdA1, 32'h0000BBBB);
        check_all();
        wa0 = 5'd7; wd0 = 32'hAAAA0000; we0 = 1'b1;
        wa1 = 5'd8; wd1 = 32'h0000BBBB; we1 = 1'b1;
        cyc(); idle(); ra1 = 5'd7; ra2 = 5'd8;
        #1 check("r7_split", rdA1, 32'hAAAA0000);
        check("r8_split", rdA2, 32'h0000BBBB);
        check_all();

        // Register 0 writes and issue.
        wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'hFFFFFFFF; wd1 = 32'hFFFFFFFF;
        we0 = 1'b1; we1 = 1'b1; iss = 1'b1; ia = 5'd0; ra1 = 5'd0;
        #1 check("r0_bypass_zero", rdA1, 32'h0);
        check_all();
        cyc(); idle(); ra1 = 5'd0;
        #1 check("r0_zero_A", rdA1, 32'h0);
        check("r0_busy_A", {31'b0, bA1}, 32'h0);
        check("r0_written_B", {16'b0, rdB1}, 32'h0000FFFF);
        check_all();

        // Scoreboard on r9.
        iss = 1'b1; ia = 5'd9; ra1 = 5'd9;
        #1 check("r9_busy_not_bypassed", {31'b0, bA1}, 32'h0);
        cyc(); idle(); ra1 = 5'd9;
        #1 check("r9_busy_set", {31'b0, bA1}, 32'h1);
        check("r9_any_set", {31'b0, anyA}, 32'h1);
        check_all();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h11;
        cyc(); idle(); ra1 = 5'd9;
        #1 check("r9_busy_after_p0", {31'b0, bA1}, 32'h1);
        check_all();
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h22; iss = 1'b1; ia = 5'd9;
        cyc(); idle(); ra1 = 5'd9;
        #1 check("r9_set_wins", {31'b0, bA1}, 32'h1);
        check_all();
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h33;
        cyc(); idle(); ra1 = 5'd9;
        #1 check("r9_busy_clear", {31'b0, bA1}, 32'h0);
        check("r9_any_clear", {31'b0, anyA}, 32'h0);
        check("r9_data", rdA1, 32'h33);
        check_all();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1000; n++) begin
            we0 = 1'($urandom); we1 = 1'($urandom); iss = ($urandom_range(0, 3) == 0);
            wa0 = rnd_addr(); wa1 = rnd_addr(); ia = rnd_addr();
            wd0 = $urandom; wd1 = $urandom;
            ra1 = rnd_addr(); ra2 = rnd_addr();
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1; model_clear();
                #1 check_all();
                #1 rst = 1'b0;
            end
            #1 check_all();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the processor datapath: two combinational read ports, two clocked write ports (ALU writeback and load writeback), optional hardwired zero register, optional same-cycle write-to-read bypass, and a per-register pending-load scoreboard. It sits between decode (read and issue side) and writeback. It replaces the fixed 32x32 single-write-port register file.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy
- BYPASS, 1, 1 = a read of an address written this cycle returns the incoming write data
- Clock  in  1  rising-edge clock
- Reset  in  1  reset, asynchronous, active-high; clock Clock
- ReadAddr1, ReadAddr2  in  ADDR_W  read port addresses
- ReadData1, ReadData2  out  DATA_W  read data, combinational
- Busy1, Busy2  out  1  pending-load flag of ReadAddr1 / ReadAddr2, combinational
- WriteAddr0, WriteData0, RegWrite0  in  ADDR_W/DATA_W/1  write port 0 (ALU)
- WriteAddr1, WriteData1, RegWrite1  in  ADDR_W/DATA_W/1  write port 1 (load); also clears busy
- IssueEn  in  1  marks IssueAddr as pending a load
- IssueAddr  in  ADDR_W  destination register of the issued load
- AnyBusy  out  1  OR of all busy bits

## Operation
- Storage: 2**ADDR_W x DATA_W flops plus 2**ADDR_W busy bits.
- Reset asserted: every register = 0 and every busy bit = 0, immediately and without waiting for a clock edge. While Reset is high, writes and issues are ignored. Outputs with Reset high: ReadDataN = 0, BusyN = 0, AnyBusy = 0.
- Write: at posedge, if RegWriteN, Reg[WriteAddrN] <= WriteDataN.
  - Both ports enabled to the same address: port 1 wins. Port 0 data is discarded.
  - Different addresses: both are written.
- Zero register: with ZERO_REG=1, writes to address 0 are dropped, reads of address 0 return 0, and IssueEn to address 0 is ignored.
- Read: ReadDataN = Reg[ReadAddrN], with BYPASS=1 and priority in this order:
  1. Address 0 with ZERO_REG returns 0.
  2. RegWrite1 && WriteAddr1==ReadAddrN returns WriteData1.
  3. RegWrite0 && WriteAddr0==ReadAddrN returns WriteData0.
  4. Otherwise, the stored value.
  - With BYPASS=0, reads return stored values only. The new value is visible the cycle after the write edge.
- Scoreboard:
  - At posedge, IssueEn sets busy[IssueAddr].
  - At posedge, RegWrite1 clears busy[WriteAddr1].
  - Same address set and cleared in the same cycle: set wins, because a new load is outstanding.
  - Port 0 writes do not touch busy bits.
- BusyN = busy[ReadAddrN], with no bypass: the flag reflects registered state only.
- Issuing to an already-busy address keeps it busy. Only a single clear is required.

## Timing
- Read latency: 0 cycles, combinational from address, write inputs (bypass path) and state.
- Write latency: 1 edge. Busy set/clear latency: 1 edge.
- Reset deassertion: the first write or issue takes effect at the first posedge with Reset low.
- Reset mid-operation: any write or issue in flight at the reset edge is lost. All state is zero.
- Address wrap-around does not apply. All 2**ADDR_W addresses are valid.

## Test plan
- Reset, then read all addresses -> every ReadData = 0, Busy = 0, AnyBusy = 0. Assert Reset between edges after writing 0xDEADBEEF to r5 -> r5 reads 0 before the next edge.
- Write 0x12345678 to r3 on port 0. In the same cycle, read r3 -> BYPASS=1 returns 0x12345678 immediately; BYPASS=0 returns 0, then 0x12345678 next cycle.
- Same cycle: port 0 writes 0xAAAA0000 and port 1 writes 0x0000BBBB, both to r7 -> r7 = 0x0000BBBB. Repeat with r7/r8 -> r7 = 0xAAAA0000, r8 = 0x0000BBBB.
- ZERO_REG=1: write 0xFFFFFFFF to r0 on both ports and IssueEn to r0 -> ReadData = 0, Busy = 0. ZERO_REG=0: the same stimulus gives r0 = 0xFFFFFFFF.
- Issue load to r9 -> Busy = 1 next cycle and AnyBusy = 1. Port 0 write to r9 -> still busy. Port 1 write to r9 with IssueEn r9 in the same cycle -> still busy. Port 1 write alone -> Busy = 0 and AnyBusy = 0.
- Parameter sweep: DATA_W=16, ADDR_W=3 -> 8 registers. Random writes on both ports, compared against a reference model over 1000 cycles.
